// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, types and constants for the multi-ported register file.
package rf_pkg;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; an issue set beats a writeback clear, and x0 never goes busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NWRITE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_en,
  input  logic [AW-1:0]              iss_addr,
  input  logic [NWRITE-1:0]          wr_en,
  input  logic [NWRITE-1:0]          wr_clr,
  input  logic [NWRITE-1:0][AW-1:0]  wr_addr,
  output logic [NREGS-1:0]           busy_vec
);
  logic [NREGS-1:0] set, clr;
  always_comb begin
    set = '0;
    clr = '0;
    set[iss_addr] = iss_en;
    set[ZERO_REG] = 1'b0;
    for (int i = 0; i < NWRITE; i++)
      if (wr_en[i] && wr_clr[i]) clr[wr_addr[i]] = 1'b1;
  end
  always_ff @(posedge clk)
    busy_vec <= rst_n ? ((busy_vec & ~clr) | set) : '0;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: RV64 integer register file with NREAD/NWRITE ports and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes onto the read ports.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREAD-1:0][AW-1:0]     rd_addr,
  output logic [NREAD-1:0][XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]             rd_busy,
  input  logic [NWRITE-1:0]            wr_en,
  input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
  input  logic [NWRITE-1:0]            wr_clr,
  input  logic                         iss_en,
  input  logic [AW-1:0]                iss_addr,
  output logic [NREGS-1:0]             busy_vec
);
  xlen_t regs [NREGS];
  rf_scoreboard #(.NWRITE(NWRITE)) u_sb (
    .clk(clk), .rst_n(rst_n), .iss_en(iss_en), .iss_addr(iss_addr),
    .wr_en(wr_en), .wr_clr(wr_clr), .wr_addr(wr_addr), .busy_vec(busy_vec)
  );
  // Later ports are assigned last, so the highest-index port wins a collision.
  always_ff @(posedge clk)
    if (!rst_n) regs <= '{default: '0};
    else
      for (int i = 0; i < NWRITE; i++)
        if (wr_en[i] && wr_addr[i] != ZERO_REG) regs[wr_addr[i]] <= wr_data[i];
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NREAD; j++) begin
      rd_data[j] = rd_addr[j] == ZERO_REG ? '0 : regs[rd_addr[j]];
      rd_busy[j] = busy_vec[rd_addr[j]];
`ifdef RF_BYPASS_EN
      for (int i = 0; i < NWRITE; i++)
        if (rst_n && wr_en[i] && wr_addr[i] == rd_addr[j] && rd_addr[j] != ZERO_REG) begin
          rd_data[j] = wr_data[i];
          rd_busy[j] = busy_vec[rd_addr[j]] && !wr_clr[i];
        end
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp (3 read, 2 write ports) against an array model.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0][4:0] rd_addr;
  logic [2:0][63:0] rd_data;
  logic [2:0] rd_busy;
  logic [1:0] wr_en, wr_clr;
  logic [1:0][4:0] wr_addr;
  logic [1:0][63:0] wr_data;
  logic iss_en;
  logic [4:0] iss_addr;
  logic [31:0] busy_vec;
  int n_vec = 0, n_err = 0;
  logic [63:0] m_regs [32];
  bit m_busy [32];

  reg_file_mp #(.NREAD(3), .NWRITE(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input int j);
    logic [63:0] v;
    v = rd_addr[j] == 0 ? 64'd0 : m_regs[rd_addr[j]];
`ifdef RF_BYPASS_EN
    for (int i = 0; i < 2; i++)
      if (rst_n && wr_en[i] && wr_addr[i] == rd_addr[j] && rd_addr[j] != 0) v = wr_data[i];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int j);
    logic b;
    b = rd_addr[j] != 0 && m_busy[rd_addr[j]];
`ifdef RF_BYPASS_EN
    for (int i = 0; i < 2; i++)
      if (rst_n && wr_en[i] && wr_addr[i] == rd_addr[j] && rd_addr[j] != 0) b = b && !wr_clr[i];
`endif
    return b;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_edge();
    bit clear;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
      return;
    end
    for (int r = 1; r < 32; r++) begin
      clear = 0;
      for (int i = 0; i < 2; i++) if (wr_en[i] && wr_clr[i] && wr_addr[i] == r) clear = 1;
      if (iss_en && iss_addr == r) m_busy[r] = 1;
      else if (clear) m_busy[r] = 0;
    end
    for (int i = 0; i < 2; i++) if (wr_en[i] && wr_addr[i] != 0) m_regs[wr_addr[i]] = wr_data[i];
  endtask

  task automatic step();
    #2;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rd_data%0d", j), rd_data[j], exp_data(j));
      chk($sformatf("rd_busy%0d", j), 64'(rd_busy[j]), 64'(exp_busy(j)));
    end
    chk("busy_vec", 64'(busy_vec), 64'(exp_vec()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; wr_en = '0; wr_clr = '0; iss_en = 1'b0;
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    rst_n = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
    step();
    // preload, then a reset that must override a concurrent write and issue
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_data[0] = 64'h77; wr_addr[1] = 5'd9; wr_data[1] = 64'h99;
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    rst_n = 1'b0; wr_addr[0] = 5'd6; iss_addr = 5'd6;
    step();
    idle(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd9; rd_addr[2] = 5'd6;
    #1;
    chk("reset_rd5", rd_data[0], 64'd0);
    chk("reset_rd9", rd_data[1], 64'd0);
    chk("reset_vec", 64'(busy_vec), 64'd0);
    step();
    // x0 protection
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 64'hDEAD_BEEF;
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = '0;
    step();
    idle();
    #1;
    chk("x0_data", rd_data[0], 64'd0);
    chk("x0_busy", 64'(busy_vec[0]), 64'd0);
    // write port priority
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_data[0] = 64'h1111; wr_addr[1] = 5'd5; wr_data[1] = 64'h2222;
    step();
    idle(); rd_addr[0] = 5'd5;
    #1;
    chk("prio_x5", rd_data[0], 64'h2222);
    // scoreboard lifecycle and set-vs-clear collision
    iss_en = 1'b1; iss_addr = 5'd7;
    step();
    idle(); rd_addr[1] = 5'd7;
    #1;
    chk("sb_set7", 64'(busy_vec[7]), 64'd1);
    wr_en[0] = 1'b1; wr_clr[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 64'h70;
    step();
    idle();
    #1;
    chk("sb_clr7", 64'(busy_vec[7]), 64'd0);
    iss_en = 1'b1; iss_addr = 5'd7; wr_en[1] = 1'b1; wr_clr[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 64'h71;
    step();
    idle();
    #1;
    chk("sb_setwins7", 64'(busy_vec[7]), 64'd1);
    // bypass of a retiring write
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 64'h1234; iss_en = 1'b1; iss_addr = 5'd3;
    step();
    idle(); wr_en[0] = 1'b1; wr_clr[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 64'hABCD; rd_addr[0] = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_data", rd_data[0], 64'hABCD);
    chk("byp_busy", 64'(rd_busy[0]), 64'd0);
`else
    chk("nobyp_data", rd_data[0], 64'h1234);
    chk("nobyp_busy", 64'(rd_busy[0]), 64'd1);
`endif
    step();
    idle();
    #1;
    chk("byp_next", rd_data[0], 64'hABCD);
    chk("byp_vec3", 64'(busy_vec[3]), 64'd0);
    // multi-port read of a busy register
    wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 64'h5A5A; iss_en = 1'b1; iss_addr = 5'd9;
    step();
    idle(); rd_addr = {5'd9, 5'd9, 5'd9};
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("mp_data%0d", j), rd_data[j], 64'h5A5A);
      chk($sformatf("mp_busy%0d", j), 64'(rd_busy[j]), 64'd1);
    end
    step();
    // randomized traffic, addresses often confined to a small window to force collisions
    for (int k = 0; k < 400; k++) begin
      rst_n = $urandom_range(0, 39) != 0;
      wr_en = 2'($urandom);
      wr_clr = 2'($urandom);
      iss_en = 1'($urandom);
      for (int i = 0; i < 2; i++) begin
        wr_addr[i] = k[0] ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wr_data[i] = {$urandom, $urandom};
      end
      iss_addr = k[0] ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int j = 0; j < 3; j++) rd_addr[j] = k[0] ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Multi-ported integer register file for the RV64 core.
- Configurable count of read and write ports; x0 hardwired to zero.
- Per-register busy scoreboard: set at issue, cleared at writeback.
- Compile-time write-to-read bypass.
- Sits between decode/issue (reads, busy checks) and writeback (writes).

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >= 2).
- NREAD, 2, number of read ports (>= 1).
- NWRITE, 1, number of write ports (>= 1).
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rd_addr  input  NREAD x AW  read addresses.
- rd_data  output  NREAD x XLEN  read data, combinational.
- rd_busy  output  NREAD  busy bit of the addressed register, combinational.
- wr_en  input  NWRITE  write enables.
- wr_addr  input  NWRITE x AW  write addresses.
- wr_data  input  NWRITE x XLEN  write data.
- wr_clr  input  NWRITE  this write retires a pending result; clears busy.
- iss_en  input  1  issue strobe; marks iss_addr busy.
- iss_addr  input  AW  destination register of the issuing instruction.
- busy_vec  output  NREGS  full scoreboard snapshot, registered state.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, all NREGS registers <= 0 and all busy bits <= 0. All other inputs are ignored that cycle. After reset, every rd_data=0, every rd_busy=0 and busy_vec=0.
- x0:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - busy bit 0 is never set; rd_busy for address 0 is always 0.
- Write:
  - wr_en[i]=1 with wr_addr[i]!=0 writes wr_data[i] at the edge. Latency 1; visible on rd_data the next cycle (or same cycle with bypass, see Optional Feature).
  - Several enabled ports targeting the same address: the highest-index port wins.
- Read: rd_data[j] = register[rd_addr[j]]; purely combinational, zero cycles. Ports are independent, and any two ports may use the same address.
- Scoreboard, next state per register r != 0:
  - set if iss_en && iss_addr==r.
  - else cleared if any i has wr_en[i] && wr_clr[i] && wr_addr[i]==r.
  - else held.
  - Set and clear of the same register in one cycle: set wins (a new producer supersedes).
  - wr_en=1 with wr_clr=0 writes data but leaves busy untouched.
  - wr_clr is ignored when wr_en=0.
- rd_busy[j] = busy[rd_addr[j]] from registered state; no same-cycle forwarding of iss_en or clears.
- A write to a non-busy register is legal: data updates and busy stays 0.
- Reset mid-operation: reset overrides any concurrent write, issue or clear.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - rd_data[j] forwards wr_data[i] in the same cycle when wr_en[i] && wr_addr[i]==rd_addr[j] && rd_addr[j]!=0.
  - If several write ports match, the highest-index port is forwarded (matches write priority).
  - rd_busy[j] is forced to 0 when a matching forwarded write has wr_clr=1.
  - No forwarding occurs while rst_n=0; rd_data reflects stored state.
- Not defined: reads return stored state only; same-cycle writes appear next cycle.

Decomposition:
- Package rf_pkg holds:
  - constants XLEN, NREGS, AW;
  - typedef xlen_t (logic [XLEN-1:0]);
  - typedef reg_addr_t (logic [AW-1:0]);
  - constant ZERO_REG = '0.
- One sub-module, rf_scoreboard:
  - busy bit array, issue-set/writeback-clear priority, x0 masking;
  - outputs busy_vec.
- reg_file_mp instantiates it and owns the data array, write priority, read muxes and bypass.

Test Plan:
- Reset then read:
  - Stimulus: preload via writes, assert rst_n=0 for one edge.
  - Required: all rd_data=0 and busy_vec=0 afterwards.
- x0 protection:
  - Stimulus: wr_en[0]=1, wr_addr=0, wr_data=64'hDEAD_BEEF; iss_en=1, iss_addr=0.
  - Required: rd_data for address 0 = 0; busy_vec[0]=0.
- Write port priority:
  - Stimulus: NWRITE=2, both ports write x5, port0=64'h1111, port1=64'h2222.
  - Required: next cycle rd_data(x5)=64'h2222.
- Scoreboard lifecycle and collision:
  - Stimulus: iss x7; next cycle wr x7 with wr_clr=1.
  - Required: busy[7] is 1 for one cycle, then 0.
  - Stimulus: iss x7 again in the same cycle as a wr_clr to x7.
  - Required: busy[7]=1 (set wins).
- Bypass, RF_BYPASS_EN defined:
  - Stimulus: wr x3=64'hABCD with wr_clr=1 while rd_addr[0]=3.
  - Required: same-cycle rd_data[0]=64'hABCD and rd_busy[0]=0.
  - Undefined build: old value this cycle, 64'hABCD next cycle.
- Multi-port read:
  - Stimulus: NREAD=3, all ports read x9=64'h5A5A while x9 is busy.
  - Required: all three rd_data=64'h5A5A and all rd_busy=1.
